// File: rtl/spi_pkg.sv
// Shared types for the multi-slave SPI master: FSM states, mode bits and mode-field positions.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } spi_state_e;

  // Bit order matches the mode port: cpha is mode[1], cpol is mode[0].
  typedef struct packed {
    logic cpha;
    logic cpol;
  } spi_mode_t;

  localparam int CPOL_BIT = 0;
  localparam int CPHA_BIT = 1;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: half-period divider, SCLK toggling and leading/trailing edge strobes.
module spi_sclk_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             toggle,
  input  logic             cpol,
  input  logic [DIV_W-1:0] div,
  output logic             tick,
  output logic             lead,
  output logic             trail,
  output logic             sclk
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;

  // Count down to zero and reload, so an all-ones divider never wraps past its range.
  assign tick  = run && (cnt_q == '0);
  assign lead  = tick && toggle && (sclk_q == cpol);
  assign trail = tick && toggle && (sclk_q != cpol);
  assign sclk  = sclk_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!run) begin
      cnt_d  = div;
      sclk_d = cpol;
    end else if (tick) begin
      cnt_d = div;
      if (toggle) sclk_d = ~sclk_q;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_master_mc.sv
// Multi-slave SPI master, CPOL/CPHA modes 0-3, full-duplex, MSB first, programmable SCLK divider.
// Build option: define SPI_LOOPBACK_EN to sample the master's own mosi instead of the miso pin.
module spi_master_mc
  import spi_pkg::*;
#(
  parameter int  WIDTH  = 8,
  parameter int  NUM_CS = 4,
  parameter int  DIV_W  = 8,
  localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_en,
  input  logic [WIDTH-1:0]  tx_data,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic [1:0]        mode,
  input  logic [DIV_W-1:0]  clk_div,
  output logic              ready,
  output logic [WIDTH-1:0]  rx_data,
  output logic              rx_valid,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);

  localparam int                EDGE_W    = $clog2(2 * WIDTH);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * WIDTH - 1);

  spi_state_e        state_q;
  spi_mode_t         mode_q;
  logic [DIV_W-1:0]  clk_div_q;
  logic [WIDTH-1:0]  sr_q;
  logic [EDGE_W-1:0] edge_q;
  logic [WIDTH-1:0]  rx_data_q;
  logic              ready_q, rx_valid_q, mosi_q;
  logic [NUM_CS-1:0] cs_n_q;

  logic tick, lead, trail, din;
  logic gen_cpol;
  logic [DIV_W-1:0] gen_div;
  logic shift_edge, sample_edge;

  // An out-of-range index matches no line, so every select stays high.
  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
    cs_decode = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (sel == CS_W'(i)) cs_decode[i] = 1'b0;
    end
  endfunction

`ifdef SPI_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = miso;
  assign din         = mosi_q;
`else
  assign din = miso;
`endif

  // While idle the generator tracks the live inputs so the accept edge loads fresh values.
  assign gen_cpol = (state_q == IDLE) ? mode[CPOL_BIT] : mode_q.cpol;
  assign gen_div  = (state_q == IDLE) ? clk_div : clk_div_q;

  spi_sclk_gen #(.DIV_W(DIV_W)) u_sclk_gen (
    .clk    (clk),
    .rst    (rst),
    .run    (state_q != IDLE),
    .toggle (state_q == SHIFT),
    .cpol   (gen_cpol),
    .div    (gen_div),
    .tick   (tick),
    .lead   (lead),
    .trail  (trail),
    .sclk   (sclk)
  );

  assign shift_edge  = mode_q.cpha ? lead : trail;
  assign sample_edge = mode_q.cpha ? trail : lead;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mode_q     <= '0;
      clk_div_q  <= '0;
      sr_q       <= '0;
      edge_q     <= '0;
      rx_data_q  <= '0;
      ready_q    <= 1'b1;
      rx_valid_q <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= '1;
    end else begin
      rx_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          cs_n_q  <= '1;
          if (tx_en) begin
            state_q   <= SETUP;
            ready_q   <= 1'b0;
            mode_q    <= spi_mode_t'(mode);
            clk_div_q <= clk_div;
            sr_q      <= tx_data;
            edge_q    <= '0;
            cs_n_q    <= cs_decode(cs_sel);
            mosi_q    <= mode[CPHA_BIT] ? 1'b0 : tx_data[WIDTH-1];
          end
        end
        SETUP: begin
          if (tick) state_q <= SHIFT;
        end
        SHIFT: begin
          if (shift_edge)  mosi_q <= sr_q[WIDTH-1];
          if (sample_edge) sr_q   <= {sr_q[WIDTH-2:0], din};
          if (tick) begin
            edge_q <= edge_q + 1'b1;
            if (edge_q == LAST_EDGE) begin
              edge_q  <= '0;
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            state_q    <= IDLE;
            cs_n_q     <= '1;
            rx_data_q  <= sr_q;
            rx_valid_q <= 1'b1;
            ready_q    <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready    = ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;

endmodule

// File: tb/tb_spi_master_mc.sv
// Directed self-checking bench for spi_master_mc with a behavioural SPI slave model.
module tb_spi_master_mc;

  logic       clk = 1'b0;
  logic       rst, tx_en, tx_en3;
  logic [7:0] tx_data, clk_div, rx_data, rx_data3;
  logic [1:0] cs_sel, mode;
  logic       ready, rx_valid, sclk, mosi, miso;
  logic [3:0] cs_n;
  logic       ready3, rx_valid3, unused_sclk3, unused_mosi3;
  logic [2:0] cs_n3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  spi_master_mc #(.WIDTH(8), .NUM_CS(4), .DIV_W(8)) u_dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .tx_data(tx_data), .cs_sel(cs_sel),
    .mode(mode), .clk_div(clk_div), .ready(ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  // Three selects, so index 3 is out of range and no line may drop.
  spi_master_mc #(.WIDTH(8), .NUM_CS(3), .DIV_W(8)) u_dut3 (
    .clk(clk), .rst(rst), .tx_en(tx_en3), .tx_data(tx_data), .cs_sel(cs_sel),
    .mode(mode), .clk_div(clk_div), .ready(ready3), .rx_data(rx_data3),
    .rx_valid(rx_valid3), .sclk(unused_sclk3), .mosi(unused_mosi3), .miso(1'b1), .cs_n(cs_n3)
  );

  // Slave: returns s_tx MSB first and captures mosi into s_rx on its sampling edges.
  logic [7:0] s_tx, s_rx;
  logic [1:0] s_mode;
  int         s_bit;
  logic       miso_s, miso_tie;

  assign miso = miso_tie ? 1'b1 : miso_s;

  always @(cs_n) begin
    if (cs_n !== 4'hF) begin
      s_bit  = 7;
      s_rx   = '0;
      miso_s = s_mode[1] ? 1'b0 : s_tx[7];
    end
  end

  always @(sclk) begin
    if (cs_n !== 4'hF) begin
      if (sclk !== s_mode[0]) begin
        if (s_mode[1]) miso_s = s_tx[s_bit];
        else           s_rx   = {s_rx[6:0], mosi};
      end else if (s_mode[1]) begin
        s_rx = {s_rx[6:0], mosi};
        s_bit--;
      end else if (s_bit > 0) begin
        s_bit--;
        miso_s = s_tx[s_bit];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_rx(input logic [7:0] tx, input logic [7:0] rsp);
`ifdef SPI_LOOPBACK_EN
    return tx;
`else
    return rsp;
`endif
  endfunction

  task automatic run_xfer(input string tag, input logic [7:0] tx, input logic [7:0] rsp,
                          input logic [1:0] md, input logic [7:0] div, input logic [1:0] sel,
                          input int exp_lat);
    int         lat;
    logic [3:0] low_seen;
    @(negedge clk);
    tx_data = tx; mode = md; clk_div = div; cs_sel = sel; s_tx = rsp; s_mode = md;
    repeat (2) @(negedge clk);
    check({tag, "/idle_sclk"}, 32'(sclk), 32'(md[0]));
    check({tag, "/ready_idle"}, 32'(ready), 32'd1);
    tx_en = 1'b1;
    @(negedge clk);
    // Scrambled inputs and a repeated request while busy must have no effect.
    tx_data = ~tx; mode = ~md; clk_div = 8'd0; cs_sel = sel + 2'd1;
    check({tag, "/ready_busy"}, 32'(ready), 32'd0);
    tx_en = 1'b0;
    lat = 0;
    low_seen = '0;
    do begin
      @(posedge clk); #1;
      lat++;
      low_seen |= ~cs_n;
      if (lat == 3) begin tx_en = 1'b1; @(negedge clk); tx_en = 1'b0; end
    end while (!rx_valid && lat < 6000);
    check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "/rx_data"}, 32'(rx_data), 32'(exp_rx(tx, rsp)));
    check({tag, "/slave_rx"}, 32'(s_rx), 32'(tx));
    check({tag, "/cs_n_done"}, 32'(cs_n), 32'hF);
    check({tag, "/cs_lines"}, 32'(low_seen), 32'(4'b0001 << sel));
    @(posedge clk); #1;
    check({tag, "/valid_pulse"}, 32'(rx_valid), 32'd0);
    check({tag, "/ready_after"}, 32'(ready), 32'd1);
  endtask

  initial begin
    int         edges, c, n_valid, v1, v2, gap, lat;
    logic       prev, hi;
    rst = 1'b1; tx_en = 1'b0; tx_en3 = 1'b0; tx_data = '0; cs_sel = '0; mode = '0;
    clk_div = '0; s_tx = '0; s_mode = '0; miso_s = 1'b0;
`ifdef SPI_LOOPBACK_EN
    miso_tie = 1'b1;
`else
    miso_tie = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst/ready", 32'(ready), 32'd1);
    check("rst/rx_valid", 32'(rx_valid), 32'd0);
    check("rst/rx_data", 32'(rx_data), 32'd0);
    check("rst/sclk", 32'(sclk), 32'd0);
    check("rst/mosi", 32'(mosi), 32'd0);
    check("rst/cs_n", 32'(cs_n), 32'hF);
    rst = 1'b0;

    // Reset in the middle of a transfer, right after the 5th SCLK edge.
    tx_data = 8'hA5; mode = 2'd0; clk_div = 8'd1; cs_sel = 2'd1; s_tx = 8'hFF; s_mode = 2'd0;
    repeat (2) @(negedge clk);
    tx_en = 1'b1;
    @(negedge clk);
    tx_en = 1'b0;
    prev = sclk; edges = 0; c = 0;
    while (edges < 5 && c < 200) begin
      @(posedge clk); #1;
      c++;
      if (sclk !== prev) begin edges++; prev = sclk; end
    end
    check("midrst/edges_seen", 32'(edges), 32'd5);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst/cs_n", 32'(cs_n), 32'hF);
    check("midrst/ready", 32'(ready), 32'd1);
    check("midrst/rx_valid", 32'(rx_valid), 32'd0);
    check("midrst/rx_data", 32'(rx_data), 32'd0);
    check("midrst/sclk", 32'(sclk), 32'd0);
    check("midrst/mosi", 32'(mosi), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n_valid = 0;
    repeat (60) begin @(posedge clk); #1; if (rx_valid) n_valid++; end
    check("midrst/no_valid", 32'(n_valid), 32'd0);

    // Mode 0 reference transfers, then modes 1-3 with an echoing slave.
    run_xfer("m0_a5", 8'hA5, 8'h3C, 2'd0, 8'd1, 2'd1, 36);
    run_xfer("m0_d3", 8'h1E, 8'hD2, 2'd0, 8'd3, 2'd0, 72);
    run_xfer("m1_81", 8'h81, 8'h81, 2'd1, 8'd1, 2'd3, 36);
    run_xfer("m2_81", 8'h81, 8'h81, 2'd2, 8'd1, 2'd0, 36);
    run_xfer("m3_81", 8'h81, 8'h81, 2'd3, 8'd1, 2'd1, 36);
    run_xfer("m1_4d", 8'h4D, 8'hB2, 2'd1, 8'd0, 2'd2, 18);
    run_xfer("cs2", 8'h6C, 8'h93, 2'd2, 8'd0, 2'd2, 18);

    // Out-of-range select on the three-select instance.
    @(negedge clk);
    tx_data = 8'h3C; mode = 2'd0; clk_div = 8'd0; cs_sel = 2'd3;
    repeat (2) @(negedge clk);
    tx_en3 = 1'b1;
    @(negedge clk);
    tx_en3 = 1'b0;
    lat = 0; hi = 1'b1;
    if (cs_n3 !== 3'b111) hi = 1'b0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (cs_n3 !== 3'b111) hi = 1'b0;
    end while (!rx_valid3 && lat < 200);
    check("oor/latency", 32'(lat), 32'd18);
    check("oor/cs_n_high", 32'(hi), 32'd1);
    check("oor/rx_data", 32'(rx_data3), 32'(exp_rx(8'h3C, 8'hFF)));
    @(posedge clk); #1;
    check("oor/ready", 32'(ready3), 32'd1);

    // Back-to-back with tx_en held high and the fastest SCLK.
    @(negedge clk);
    tx_data = 8'h4B; mode = 2'd0; clk_div = 8'd0; cs_sel = 2'd0; s_tx = 8'h96; s_mode = 2'd0;
    repeat (2) @(negedge clk);
    tx_en = 1'b1;
    @(posedge clk); #1;
    n_valid = 0; v1 = 0; v2 = 0; gap = 0;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk); #1;
      if (k == 1) tx_data = 8'hB4;
      if (k == 19) tx_en = 1'b0;
      if (k <= 36 && cs_n == 4'hF) gap++;
      if (rx_valid) begin
        n_valid++;
        if (n_valid == 1) begin
          v1 = k;
          check("b2b/rx1", 32'(rx_data), 32'(exp_rx(8'h4B, 8'h96)));
          check("b2b/slave1", 32'(s_rx), 32'h4B);
        end else if (n_valid == 2) begin
          v2 = k;
          check("b2b/rx2", 32'(rx_data), 32'(exp_rx(8'hB4, 8'h96)));
          check("b2b/slave2", 32'(s_rx), 32'hB4);
        end
      end
    end
    check("b2b/n_valid", 32'(n_valid), 32'd2);
    check("b2b/valid1_at", 32'(v1), 32'd18);
    check("b2b/valid2_at", 32'(v2), 32'd37);
    check("b2b/cs_gap", 32'(gap), 32'd1);

    // Largest divider: counter must reload without wrapping.
    run_xfer("div_ff", 8'h35, 8'hE8, 2'd3, 8'hFF, 2'd3, 4608);

`ifdef SPI_LOOPBACK_EN
    for (int m = 0; m < 4; m++) begin
      run_xfer($sformatf("lb_m%0d", m), 8'h5A, 8'h00, 2'(m), 8'd1, 2'(m), 36);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
